// File: rtl/onehot_to_binary_stream.sv
// onehot_to_binary_stream: streaming one-hot to binary encoder with a
// 2-entry output buffer and a saturating illegal-code counter.
// Optional build macro ONEHOT_PRIORITY_EN: multi-hot words encode the index
// of their lowest set bit and are treated as legal; all-zero stays illegal.
module onehot_to_binary_stream #(
    parameter int BINARY_WIDTH  = 4,
    parameter int ONE_HOT_WIDTH = 16,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ONE_HOT_WIDTH-1:0] in_onehot,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BINARY_WIDTH-1:0]  out_bin,
    output logic                     out_err,
    input  logic                     err_clr,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    generate
        if (ONE_HOT_WIDTH > (1 << BINARY_WIDTH)) begin : gBadParams
            $error("ONE_HOT_WIDTH must not exceed 2**BINARY_WIDTH");
        end
    endgenerate

    // Buffer occupancy; transitions are driven by accept/transfer handshakes.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    // Buffer entries are packed as {bin, err}.
    localparam int ENTRY_W = BINARY_WIDTH + 1;

    occ_t                     occ_q, occ_d;
    logic [ENTRY_W-1:0]       headEntry_q, headEntry_d;
    logic [ENTRY_W-1:0]       tailEntry_q, tailEntry_d;
    logic                     inReady_q, inReady_d;
    logic [ERR_CNT_WIDTH-1:0] errCount_q, errCount_d;

    logic [BINARY_WIDTH-1:0]  lowIdx;
    logic                     anyHot;
`ifndef ONEHOT_PRIORITY_EN
    logic                     multiHot;
`endif
    logic [BINARY_WIDTH-1:0]  encBin;
    logic                     encErr;
    logic                     push;
    logic                     pop;
    logic                     illegalAccept;

    // Encode the incoming word: find the lowest set bit and detect zero/multi-hot.
    always_comb begin
        lowIdx = '0;
        anyHot = 1'b0;
`ifndef ONEHOT_PRIORITY_EN
        multiHot = 1'b0;
`endif
        for (int i = 0; i < ONE_HOT_WIDTH; i++) begin
            if (in_onehot[i]) begin
                if (!anyHot) begin
                    lowIdx = BINARY_WIDTH'(i);
                end
`ifndef ONEHOT_PRIORITY_EN
                else begin
                    multiHot = 1'b1;
                end
`endif
                anyHot = 1'b1;
            end
        end
`ifdef ONEHOT_PRIORITY_EN
        encBin = anyHot ? lowIdx : '0;
        encErr = !anyHot;
`else
        encBin = (anyHot && !multiHot) ? lowIdx : '0;
        encErr = !anyHot || multiHot;
`endif
    end

    // Next-state logic for the 2-entry FIFO, the registered ready and the error counter.
    always_comb begin
        push          = in_valid && inReady_q;
        pop           = (occ_q != OCC_EMPTY) && out_ready;
        illegalAccept = push && encErr;
        occ_d         = occ_q;
        headEntry_d   = headEntry_q;
        tailEntry_d   = tailEntry_q;
        errCount_d    = errCount_q;

        case (occ_q)
            OCC_EMPTY: begin
                if (push) begin
                    headEntry_d = {encBin, encErr};
                    occ_d       = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push && pop) begin
                    headEntry_d = {encBin, encErr};
                end else if (push) begin
                    tailEntry_d = {encBin, encErr};
                    occ_d       = OCC_FULL;
                end else if (pop) begin
                    headEntry_d = '0;
                    occ_d       = OCC_EMPTY;
                end
            end
            default: begin
                if (pop) begin
                    headEntry_d = tailEntry_q;
                    tailEntry_d = '0;
                    occ_d       = OCC_ONE;
                end
            end
        endcase

        inReady_d = (occ_d != OCC_FULL);

        if (err_clr) begin
            errCount_d = illegalAccept ? ERR_CNT_WIDTH'(1) : '0;
        end else if (illegalAccept && (errCount_q != {ERR_CNT_WIDTH{1'b1}})) begin
            errCount_d = errCount_q + ERR_CNT_WIDTH'(1);
        end
    end

    // State registers; reset discards buffered entries immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q       <= OCC_EMPTY;
            headEntry_q <= '0;
            tailEntry_q <= '0;
            inReady_q   <= 1'b1;
            errCount_q  <= '0;
        end else begin
            occ_q       <= occ_d;
            headEntry_q <= headEntry_d;
            tailEntry_q <= tailEntry_d;
            inReady_q   <= inReady_d;
            errCount_q  <= errCount_d;
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = (occ_q != OCC_EMPTY);
    assign out_bin   = headEntry_q[ENTRY_W-1:1];
    assign out_err   = headEntry_q[0];
    assign err_count = errCount_q;

endmodule

// File: tb/tb_onehot_to_binary_stream.sv
// Testbench for onehot_to_binary_stream: table-driven words feed a scoreboard
// queue; a negedge monitor checks handshakes, ordering and error counts.
module tb_onehot_to_binary_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic [15:0] inOnehot;
    logic        outReady;
    logic        errClr;

    logic        inReady, outValid, outErr;
    logic [3:0]  outBin;
    logic [7:0]  errCount;

    logic        inReady2, outValid2, outErr2;
    logic [3:0]  outBin2;
    logic [1:0]  errCount2;

    int checks = 0;
    int errors = 0;

    // Expected encoding of the word currently offered on the input.
    logic [3:0]  curExpBin;
    logic        curExpErr;

    logic [4:0]  sbq[$];
    logic [4:0]  expEntry;
    int          errModel;
    int          errModel2;
    logic        acceptIllegal;

    typedef struct {
        logic [15:0] oh;
        logic [3:0]  bin;
        logic        err;
    } vec_t;
    vec_t vecs[20];

    always #5 clk = ~clk;

    onehot_to_binary_stream dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_onehot (inOnehot),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_bin   (outBin),
        .out_err   (outErr),
        .err_clr   (errClr),
        .err_count (errCount)
    );

    // Narrow-counter copy sharing all inputs, used for saturation checks.
    onehot_to_binary_stream #(.ERR_CNT_WIDTH(2)) dutSat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady2),
        .in_onehot (inOnehot),
        .out_valid (outValid2),
        .out_ready (outReady),
        .out_bin   (outBin2),
        .out_err   (outErr2),
        .err_clr   (errClr),
        .err_count (errCount2)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Offer one word and hold it until accepted (bounded); returns cycles spent.
    task automatic applyStimulus(input logic [15:0] oh, input logic [3:0] bin,
                                 input logic err, output int waited);
        logic acc;
        inOnehot  = oh;
        curExpBin = bin;
        curExpErr = err;
        inValid   = 1'b1;
        waited    = 0;
        acc       = 1'b0;
        while (!acc && waited < 20) begin
            @(negedge clk);
            acc = inReady;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
        inValid = 1'b0;
    endtask

    // Wait (bounded) until the scoreboard and the DUT buffer are both empty.
    task automatic waitDrain();
        logic drained;
        drained = 1'b0;
        for (int i = 0; i < 50 && !drained; i++) begin
            @(negedge clk);
            #1;
            if (sbq.size() == 0 && !outValid) drained = 1'b1;
        end
        checkOutput("drain", {31'd0, drained}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare flow-control and outputs against the scoreboard each cycle.
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            errModel  = 0;
            errModel2 = 0;
        end else begin
            checkOutput("in_ready", {31'd0, inReady}, {31'd0, sbq.size() < 2});
            checkOutput("out_valid", {31'd0, outValid}, {31'd0, sbq.size() != 0});
            checkOutput("in_ready_sat", {31'd0, inReady2}, {31'd0, sbq.size() < 2});
            checkOutput("out_valid_sat", {31'd0, outValid2}, {31'd0, sbq.size() != 0});
            checkOutput("err_count", {24'd0, errCount}, errModel);
            checkOutput("err_count_sat", {30'd0, errCount2}, errModel2);
            if (outValid && outReady) begin
                if (sbq.size() == 0) begin
                    checkOutput("spurious_output", 32'd1, 32'd0);
                end else begin
                    expEntry = sbq.pop_front();
                    checkOutput("out_bin", {28'd0, outBin}, {28'd0, expEntry[4:1]});
                    checkOutput("out_err", {31'd0, outErr}, {31'd0, expEntry[0]});
                    checkOutput("out_bin_sat", {28'd0, outBin2}, {28'd0, expEntry[4:1]});
                    checkOutput("out_err_sat", {31'd0, outErr2}, {31'd0, expEntry[0]});
                end
            end
            acceptIllegal = inValid && inReady && curExpErr;
            if (inValid && inReady) sbq.push_back({curExpBin, curExpErr});
            if (errClr) begin
                errModel  = acceptIllegal ? 1 : 0;
                errModel2 = acceptIllegal ? 1 : 0;
            end else if (acceptIllegal) begin
                if (errModel < 255) errModel++;
                if (errModel2 < 3) errModel2++;
            end
        end
    end

    // Main test sequence.
    initial begin
        int waited;
        rst       = 1'b1;
        inValid   = 1'b0;
        inOnehot  = '0;
        outReady  = 1'b1;
        errClr    = 1'b0;
        curExpBin = '0;
        curExpErr = 1'b0;

        for (int i = 0; i < 16; i++) begin
            vecs[i].oh  = 16'd1 << i;
            vecs[i].bin = 4'(i);
            vecs[i].err = 1'b0;
        end
        vecs[16] = '{16'h0000, 4'd0, 1'b1};
`ifdef ONEHOT_PRIORITY_EN
        vecs[17] = '{16'h0009, 4'd0, 1'b0};
        vecs[18] = '{16'hFFFF, 4'd0, 1'b0};
        vecs[19] = '{16'h8010, 4'd4, 1'b0};
`else
        vecs[17] = '{16'h0009, 4'd0, 1'b1};
        vecs[18] = '{16'hFFFF, 4'd0, 1'b1};
        vecs[19] = '{16'h8010, 4'd0, 1'b1};
`endif

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {31'd0, outValid}, 32'd0);
        checkOutput("rst_out_bin", {28'd0, outBin}, 32'd0);
        checkOutput("rst_out_err", {31'd0, outErr}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, inReady}, 32'd1);
        checkOutput("rst_err_count", {24'd0, errCount}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] single word latency");
        applyStimulus(16'h0020, 4'd5, 1'b0, waited);
        checkOutput("lat_out_valid", {31'd0, outValid}, 32'd1);
        checkOutput("lat_out_bin", {28'd0, outBin}, 32'd5);
        checkOutput("lat_out_err", {31'd0, outErr}, 32'd0);
        checkOutput("lat_in_ready", {31'd0, inReady}, 32'd1);
        checkOutput("lat_err_count", {24'd0, errCount}, 32'd0);
        waitDrain();

        $display("[TB] stream all legal codes");
        for (int i = 0; i < 16; i++) begin
            checkOutput("stream_in_ready", {31'd0, inReady}, 32'd1);
            applyStimulus(vecs[i].oh, vecs[i].bin, vecs[i].err, waited);
            checkOutput("stream_no_bubble", waited, 32'd1);
        end
        waitDrain();

        $display("[TB] backpressure hold");
        outReady = 1'b0;
        applyStimulus(16'h0001, 4'd0, 1'b0, waited);
        applyStimulus(16'h0002, 4'd1, 1'b0, waited);
        checkOutput("full_in_ready", {31'd0, inReady}, 32'd0);
        inOnehot  = 16'h0004;
        curExpBin = 4'd2;
        curExpErr = 1'b0;
        inValid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_in_ready", {31'd0, inReady}, 32'd0);
            checkOutput("hold_out_valid", {31'd0, outValid}, 32'd1);
            checkOutput("hold_out_bin", {28'd0, outBin}, 32'd0);
        end
        outReady = 1'b1;
        applyStimulus(16'h0004, 4'd2, 1'b0, waited);
        waitDrain();

        $display("[TB] illegal codes");
        errClr = 1'b1;
        @(posedge clk);
        #1;
        errClr = 1'b0;
        applyStimulus(vecs[16].oh, vecs[16].bin, vecs[16].err, waited);
        applyStimulus(vecs[17].oh, vecs[17].bin, vecs[17].err, waited);
        waitDrain();
`ifdef ONEHOT_PRIORITY_EN
        checkOutput("illegal_err_count", {24'd0, errCount}, 32'd1);
`else
        checkOutput("illegal_err_count", {24'd0, errCount}, 32'd2);
`endif
        applyStimulus(vecs[18].oh, vecs[18].bin, vecs[18].err, waited);
        applyStimulus(vecs[19].oh, vecs[19].bin, vecs[19].err, waited);
        waitDrain();

        $display("[TB] counter saturation and clear");
        errClr = 1'b1;
        @(posedge clk);
        #1;
        errClr = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(16'h0000, 4'd0, 1'b1, waited);
        waitDrain();
        checkOutput("sat_err_count2", {30'd0, errCount2}, 32'd3);
        checkOutput("sat_err_count", {24'd0, errCount}, 32'd5);
        errClr = 1'b1;
        applyStimulus(16'h0000, 4'd0, 1'b1, waited);
        errClr = 1'b0;
        checkOutput("clr_acc_err_count2", {30'd0, errCount2}, 32'd1);
        checkOutput("clr_acc_err_count", {24'd0, errCount}, 32'd1);
        waitDrain();

        $display("[TB] reset mid-stream");
        outReady = 1'b0;
        applyStimulus(16'h0000, 4'd0, 1'b1, waited);
`ifdef ONEHOT_PRIORITY_EN
        applyStimulus(16'h0003, 4'd0, 1'b0, waited);
`else
        applyStimulus(16'h0003, 4'd0, 1'b1, waited);
`endif
        checkOutput("pre_rst_in_ready", {31'd0, inReady}, 32'd0);
        checkOutput("pre_rst_out_valid", {31'd0, outValid}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_out_valid", {31'd0, outValid}, 32'd0);
        checkOutput("mid_rst_in_ready", {31'd0, inReady}, 32'd1);
        checkOutput("mid_rst_err_count", {24'd0, errCount}, 32'd0);
        checkOutput("mid_rst_out_bin", {28'd0, outBin}, 32'd0);
        checkOutput("mid_rst_out_err", {31'd0, outErr}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        outReady = 1'b1;
        applyStimulus(16'h8000, 4'd15, 1'b0, waited);
        checkOutput("post_rst_out_valid", {31'd0, outValid}, 32'd1);
        checkOutput("post_rst_out_bin", {28'd0, outBin}, 32'd15);
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/onehot_to_binary_stream.md
Name: onehot_to_binary_stream

Overview:
- Streaming one-hot to binary encoder; the inverse of the team's binary-to-one-hot decoder.
- Accepts one-hot words over a valid/ready handshake and encodes each to its binary index.
- Flags illegal codes (all-zero or multi-hot) and keeps a saturating error count for status readback.
- Sits between one-hot arbitration/select logic and index-consuming datapaths; a 2-entry output buffer decouples backpressure.

Parameters:
- BINARY_WIDTH, 4, width of the encoded index.
- ONE_HOT_WIDTH, 16, width of the one-hot input. Must satisfy ONE_HOT_WIDTH <= 2**BINARY_WIDTH; otherwise elaboration fails with $error.
- ERR_CNT_WIDTH, 8, width of the saturating illegal-code counter.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept a word; registered, no combinational path from out_ready
- in_onehot  input  ONE_HOT_WIDTH  one-hot code
- out_valid  output  1  out_bin/out_err valid
- out_ready  input  1  downstream accepts
- out_bin  output  BINARY_WIDTH  encoded index
- out_err  output  1  word was illegal
- err_clr  input  1  synchronous clear of err_count
- err_count  output  ERR_CNT_WIDTH  saturating count of illegal words accepted

Behaviour:
- Reset (async assert, sync-to-clk deassert is external):
  - Buffer empty; out_valid=0; out_bin=0; out_err=0.
  - in_ready=1; err_count=0.
- Accept occurs when in_valid&&in_ready at a rising edge. Transfer occurs when out_valid&&out_ready.
- Encoding is combinational on in_onehot and stored with the entry:
  - Exactly one bit k set: bin=k, err=0.
  - Zero bits set: bin=0, err=1.
  - More than one bit set: bin=0, err=1 (see optional feature).
- Buffer is a 2-entry FIFO of {bin,err}; occupancy is 0, 1 or 2.
  - out_valid = occupancy != 0.
  - out_bin/out_err always show the head entry. They hold stable while out_valid&&!out_ready.
  - in_ready is a register: next value = (next occupancy < 2).
- Latency: word accepted at edge N appears on out_valid after edge N when the buffer was empty (1 cycle).
- Throughput: 1 word/cycle sustained when out_ready=1.
- Simultaneous accept and transfer: occupancy unchanged, order preserved.
  - At occupancy 1, the new entry becomes the head on the next cycle.
- Full (occupancy 2): in_ready=0 on that cycle. A transfer that cycle raises in_ready on the next cycle.
- Empty with out_ready=1: no transfer; out_valid stays 0.
- err_count:
  - Increments on each accepted word with err=1 and saturates at 2**ERR_CNT_WIDTH-1.
  - err_clr loads 0. If an accepted illegal word coincides with err_clr, the result is 1.
- Reset mid-operation: all buffered entries are discarded immediately; outputs return to their reset values asynchronously.
- Input X/Z is not checked; upstream must drive in_onehot valid whenever in_valid=1.

Optional Feature:
- Macro ONEHOT_PRIORITY_EN.
- Defined:
  - Multi-hot input encodes the index of the lowest set bit, with err=0 and no err_count increment.
  - Zero input is still bin=0, err=1, counted.
- Undefined: behaviour as specified above (multi-hot is illegal and counted).

Test Plan:
- Reset, then single word 16'h0020 with out_ready=1 -> one cycle later out_valid=1, out_bin=5, out_err=0; in_ready stays 1; err_count=0.
- Stream all 16 legal codes 1<<0..1<<15 back-to-back with out_ready=1 -> out_bin 0..15 in order, one per cycle, no bubbles, out_err never set.
- out_ready=0, offer 16'h0001, 16'h0002, 16'h0004 -> first two accepted; in_ready=0 after the second; the third is held. Raise out_ready -> outputs 0,1,2 in order with no loss or duplication.
- Send 16'h0000 and 16'h0009 -> out_err=1, out_bin=0 for both, err_count=2.
  - With ONEHOT_PRIORITY_EN: 16'h0009 gives out_bin=0, out_err=0, and err_count=1.
- ERR_CNT_WIDTH=2, send 5 illegal words -> err_count saturates at 3. err_clr together with an illegal accept -> err_count=1.
- Fill to 2 entries, assert rst mid-stream -> out_valid=0, in_ready=1, err_count=0 immediately. After deassert, 16'h8000 -> out_bin=15.
